// File: rtl/issue_queue_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : issue_queue_mp                                                |
// | Brief    : Multi-port age-ordered issue queue. Holds dispatched uops,    |
// |            wakes sources from CDB broadcasts and issues oldest-ready     |
// |            first to ISSUE_W execution ports.                             |
// | Options  : `define ISSUE_QUEUE_PERF_CNT_EN adds stall_cnt_o/issue_cnt_o  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module issue_queue_mp #(
    parameter int RS_DEPTH   = 16,
    parameter int DISPATCH_W = 4,
    parameter int CDB_W      = 4,
    parameter int ISSUE_W    = 2,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 6,
    parameter int OP_W       = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic [DISPATCH_W-1:0]          dispatch_valid_i,
    input  logic [DISPATCH_W*OP_W-1:0]     dispatch_op_i,
    input  logic [DISPATCH_W*TAG_W-1:0]    dispatch_dst_i,
    input  logic [DISPATCH_W*DATA_W-1:0]   dispatch_v1_i,
    input  logic [DISPATCH_W*DATA_W-1:0]   dispatch_v2_i,
    input  logic [DISPATCH_W*TAG_W-1:0]    dispatch_q1_i,
    input  logic [DISPATCH_W*TAG_W-1:0]    dispatch_q2_i,
    input  logic [DISPATCH_W-1:0]          dispatch_r1_i,
    input  logic [DISPATCH_W-1:0]          dispatch_r2_i,
    output logic                           issue_ready_o,
    output logic [$clog2(RS_DEPTH+1)-1:0]  free_count_o,
    input  logic [CDB_W-1:0]               cdb_valid_i,
    input  logic [CDB_W*TAG_W-1:0]         cdb_tag_i,
    input  logic [CDB_W*DATA_W-1:0]        cdb_val_i,
    input  logic [ISSUE_W-1:0]             alu_ready_i,
    output logic [ISSUE_W-1:0]             alu_en_o,
    output logic [ISSUE_W*OP_W-1:0]        alu_uop_o,
    output logic [ISSUE_W*DATA_W-1:0]      alu_v1_o,
    output logic [ISSUE_W*DATA_W-1:0]      alu_v2_o,
    output logic [ISSUE_W*TAG_W-1:0]       alu_dst_o
`ifdef ISSUE_QUEUE_PERF_CNT_EN
    ,
    output logic [31:0]                    stall_cnt_o,
    output logic [31:0]                    issue_cnt_o
`endif
);

    localparam int c_cnt_w  = $clog2(RS_DEPTH + 1);
    localparam int c_idx_w  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int c_slot_w = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

    // Entry storage
    logic [RS_DEPTH-1:0] r_valid;
    logic [RS_DEPTH-1:0] r_r1;
    logic [RS_DEPTH-1:0] r_r2;
    logic [OP_W-1:0]     r_op  [RS_DEPTH];
    logic [TAG_W-1:0]    r_dst [RS_DEPTH];
    logic [DATA_W-1:0]   r_v1  [RS_DEPTH];
    logic [DATA_W-1:0]   r_v2  [RS_DEPTH];
    logic [TAG_W-1:0]    r_q1  [RS_DEPTH];
    logic [TAG_W-1:0]    r_q2  [RS_DEPTH];
    // r_older[i][j] = 1 means entry i is older than entry j (meaningful for valid pairs)
    logic [RS_DEPTH-1:0] r_older [RS_DEPTH];

    logic [c_cnt_w-1:0]  w_free_count;
    logic                w_issue_ready;
    logic                w_accept;

    // CDB match result: {hit, value}; lowest matching channel wins
    function automatic logic [DATA_W:0] f_cdb_match(
        input logic [TAG_W-1:0]        tag,
        input logic [CDB_W-1:0]        vld,
        input logic [CDB_W*TAG_W-1:0]  tags,
        input logic [CDB_W*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int c = CDB_W - 1; c >= 0; c--) begin
            if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag))
                res = {1'b1, vals[c*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    // Free entries derived from the valid vector
    always_comb begin
        w_free_count = c_cnt_w'(RS_DEPTH);
        for (int e = 0; e < RS_DEPTH; e++)
            w_free_count = w_free_count - c_cnt_w'(r_valid[e]);
    end

    assign w_issue_ready = (w_free_count >= c_cnt_w'(DISPATCH_W));
    assign w_accept      = w_issue_ready && !flush_i;
    assign issue_ready_o = w_issue_ready;
    assign free_count_o  = w_free_count;

    // Wakeup lookups for resident entries and for sources being dispatched now
    logic [DATA_W:0] w_wk1  [RS_DEPTH];
    logic [DATA_W:0] w_wk2  [RS_DEPTH];
    logic [DATA_W:0] w_dwk1 [DISPATCH_W];
    logic [DATA_W:0] w_dwk2 [DISPATCH_W];

    always_comb begin
        for (int e = 0; e < RS_DEPTH; e++) begin
            w_wk1[e] = f_cdb_match(r_q1[e], cdb_valid_i, cdb_tag_i, cdb_val_i);
            w_wk2[e] = f_cdb_match(r_q2[e], cdb_valid_i, cdb_tag_i, cdb_val_i);
        end
        for (int s = 0; s < DISPATCH_W; s++) begin
            w_dwk1[s] = f_cdb_match(dispatch_q1_i[s*TAG_W +: TAG_W], cdb_valid_i, cdb_tag_i, cdb_val_i);
            w_dwk2[s] = f_cdb_match(dispatch_q2_i[s*TAG_W +: TAG_W], cdb_valid_i, cdb_tag_i, cdb_val_i);
        end
    end

    // Allocation: lowest valid slot takes the lowest free entry, and so on
    logic [RS_DEPTH-1:0] w_alloc;
    logic [RS_DEPTH-1:0] w_taken;
    logic [c_slot_w-1:0] w_alloc_slot [RS_DEPTH];
    logic                w_found;

    always_comb begin
        w_alloc = '0;
        w_taken = r_valid;
        w_found = 1'b0;
        for (int e = 0; e < RS_DEPTH; e++)
            w_alloc_slot[e] = '0;
        for (int s = 0; s < DISPATCH_W; s++) begin
            w_found = 1'b0;
            if (dispatch_valid_i[s] && w_accept) begin
                for (int e = 0; e < RS_DEPTH; e++) begin
                    if (!w_found && !w_taken[e]) begin
                        w_found         = 1'b1;
                        w_taken[e]      = 1'b1;
                        w_alloc[e]      = 1'b1;
                        w_alloc_slot[e] = c_slot_w'(s);
                    end
                end
            end
        end
    end

    // Select: ready ports in ascending order each take the oldest remaining ready entry
    logic [RS_DEPTH-1:0] w_cand;
    logic [RS_DEPTH-1:0] w_issue_mask;
    logic [ISSUE_W-1:0]  w_en;
    logic [c_idx_w-1:0]  w_sel [ISSUE_W];
    logic                w_pick_found;
    logic                w_has_older;

    always_comb begin
        w_cand       = r_valid & r_r1 & r_r2;
        w_issue_mask = '0;
        w_en         = '0;
        w_pick_found = 1'b0;
        w_has_older  = 1'b0;
        for (int k = 0; k < ISSUE_W; k++)
            w_sel[k] = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_pick_found = 1'b0;
            if (alu_ready_i[k] && !flush_i) begin
                for (int e = 0; e < RS_DEPTH; e++) begin
                    w_has_older = 1'b0;
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        if (w_cand[j] && r_older[j][e])
                            w_has_older = 1'b1;
                    end
                    if (!w_pick_found && w_cand[e] && !w_has_older) begin
                        w_pick_found = 1'b1;
                        w_sel[k]     = c_idx_w'(e);
                        w_en[k]      = 1'b1;
                    end
                end
                if (w_pick_found) begin
                    w_cand[w_sel[k]]       = 1'b0;
                    w_issue_mask[w_sel[k]] = 1'b1;
                end
            end
        end
    end

    // Issue port outputs; idle ports drive zero
    always_comb begin
        alu_en_o  = w_en;
        alu_uop_o = '0;
        alu_v1_o  = '0;
        alu_v2_o  = '0;
        alu_dst_o = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (w_en[k]) begin
                alu_uop_o[k*OP_W +: OP_W]     = r_op[w_sel[k]];
                alu_v1_o[k*DATA_W +: DATA_W]  = r_v1[w_sel[k]];
                alu_v2_o[k*DATA_W +: DATA_W]  = r_v2[w_sel[k]];
                alu_dst_o[k*TAG_W +: TAG_W]   = r_dst[w_sel[k]];
            end
        end
    end

    // Control state: valid bits, source-ready flags and age matrix
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
            for (int i = 0; i < RS_DEPTH; i++)
                r_older[i] <= '0;
        end else if (flush_i) begin
            r_valid <= '0;
        end else begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (w_alloc[e]) begin
                    r_valid[e] <= 1'b1;
                    r_r1[e]    <= dispatch_r1_i[w_alloc_slot[e]] | w_dwk1[w_alloc_slot[e]][DATA_W];
                    r_r2[e]    <= dispatch_r2_i[w_alloc_slot[e]] | w_dwk2[w_alloc_slot[e]][DATA_W];
                end else begin
                    if (w_issue_mask[e])
                        r_valid[e] <= 1'b0;
                    r_r1[e] <= r_r1[e] | w_wk1[e][DATA_W];
                    r_r2[e] <= r_r2[e] | w_wk2[e][DATA_W];
                end
            end
            // New entries are younger than residents; within a group lower slot is older
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (w_alloc[i])
                        r_older[i][j] <= w_alloc[j] && (w_alloc_slot[j] > w_alloc_slot[i]);
                    else if (w_alloc[j])
                        r_older[i][j] <= 1'b1;
                end
            end
        end
    end

    // Payload and operand storage; qualified by the valid bits, so no reset needed
    always_ff @(posedge clk) begin
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (w_alloc[e]) begin
                r_op[e]  <= dispatch_op_i[int'(w_alloc_slot[e])*OP_W +: OP_W];
                r_dst[e] <= dispatch_dst_i[int'(w_alloc_slot[e])*TAG_W +: TAG_W];
                r_q1[e]  <= dispatch_q1_i[int'(w_alloc_slot[e])*TAG_W +: TAG_W];
                r_q2[e]  <= dispatch_q2_i[int'(w_alloc_slot[e])*TAG_W +: TAG_W];
                r_v1[e]  <= (!dispatch_r1_i[w_alloc_slot[e]] && w_dwk1[w_alloc_slot[e]][DATA_W])
                          ? w_dwk1[w_alloc_slot[e]][DATA_W-1:0]
                          : dispatch_v1_i[int'(w_alloc_slot[e])*DATA_W +: DATA_W];
                r_v2[e]  <= (!dispatch_r2_i[w_alloc_slot[e]] && w_dwk2[w_alloc_slot[e]][DATA_W])
                          ? w_dwk2[w_alloc_slot[e]][DATA_W-1:0]
                          : dispatch_v2_i[int'(w_alloc_slot[e])*DATA_W +: DATA_W];
            end else begin
                if (!r_r1[e] && w_wk1[e][DATA_W])
                    r_v1[e] <= w_wk1[e][DATA_W-1:0];
                if (!r_r2[e] && w_wk2[e][DATA_W])
                    r_v2[e] <= w_wk2[e][DATA_W-1:0];
            end
        end
    end

`ifdef ISSUE_QUEUE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_issue_cnt;
    logic [31:0] w_issue_inc;

    // Number of uops issued this cycle
    always_comb begin
        w_issue_inc = '0;
        for (int k = 0; k < ISSUE_W; k++)
            w_issue_inc = w_issue_inc + 32'(w_en[k]);
    end

    // Free-running counters, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if ((|dispatch_valid_i) && !w_issue_ready)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            r_issue_cnt <= r_issue_cnt + w_issue_inc;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign issue_cnt_o = r_issue_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_issue_queue_mp                                             |
// | Brief    : Self-checking bench for issue_queue_mp: directed scenarios    |
// |            followed by randomized traffic against a queue-based model.   |
// | Options  : ISSUE_QUEUE_PERF_CNT_EN also checks the performance counters  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_issue_queue_mp;

    localparam int RS_DEPTH   = 16;
    localparam int DISPATCH_W = 4;
    localparam int CDB_W      = 4;
    localparam int ISSUE_W    = 2;
    localparam int DATA_W     = 32;
    localparam int TAG_W      = 6;
    localparam int OP_W       = 64;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          flush;
    logic [DISPATCH_W-1:0]         dispatch_valid;
    logic [DISPATCH_W*OP_W-1:0]    dispatch_op;
    logic [DISPATCH_W*TAG_W-1:0]   dispatch_dst;
    logic [DISPATCH_W*DATA_W-1:0]  dispatch_v1, dispatch_v2;
    logic [DISPATCH_W*TAG_W-1:0]   dispatch_q1, dispatch_q2;
    logic [DISPATCH_W-1:0]         dispatch_r1, dispatch_r2;
    logic                          issue_ready;
    logic [$clog2(RS_DEPTH+1)-1:0] free_count;
    logic [CDB_W-1:0]              cdb_valid;
    logic [CDB_W*TAG_W-1:0]        cdb_tag;
    logic [CDB_W*DATA_W-1:0]       cdb_val;
    logic [ISSUE_W-1:0]            alu_ready;
    logic [ISSUE_W-1:0]            alu_en;
    logic [ISSUE_W*OP_W-1:0]       alu_uop;
    logic [ISSUE_W*DATA_W-1:0]     alu_v1, alu_v2;
    logic [ISSUE_W*TAG_W-1:0]      alu_dst;
`ifdef ISSUE_QUEUE_PERF_CNT_EN
    logic [31:0]                   stall_cnt, issue_cnt;
`endif

    issue_queue_mp #(
        .RS_DEPTH(RS_DEPTH), .DISPATCH_W(DISPATCH_W), .CDB_W(CDB_W), .ISSUE_W(ISSUE_W),
        .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .dispatch_valid_i(dispatch_valid), .dispatch_op_i(dispatch_op), .dispatch_dst_i(dispatch_dst),
        .dispatch_v1_i(dispatch_v1), .dispatch_v2_i(dispatch_v2),
        .dispatch_q1_i(dispatch_q1), .dispatch_q2_i(dispatch_q2),
        .dispatch_r1_i(dispatch_r1), .dispatch_r2_i(dispatch_r2),
        .issue_ready_o(issue_ready), .free_count_o(free_count),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .alu_ready_i(alu_ready), .alu_en_o(alu_en), .alu_uop_o(alu_uop),
        .alu_v1_o(alu_v1), .alu_v2_o(alu_v2), .alu_dst_o(alu_dst)
`ifdef ISSUE_QUEUE_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt), .issue_cnt_o(issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: resident uops kept in a queue in age order (front = oldest)
    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dst;
        logic [DATA_W-1:0] v1, v2;
        logic [TAG_W-1:0]  q1, q2;
        bit                r1, r2;
    } ent_t;

    ent_t        mq [$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_stall = 0;
    logic [31:0] exp_issue = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // First (lowest-numbered) CDB channel broadcasting the tag
    function automatic bit cdb_find(input logic [TAG_W-1:0] tag, output logic [DATA_W-1:0] val);
        val = '0;
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == tag) begin
                val = cdb_val[c*DATA_W +: DATA_W];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        flush          = 1'b0;
        dispatch_valid = '0;
        dispatch_r1    = '0;
        dispatch_r2    = '0;
        cdb_valid      = '0;
    endtask

    task automatic set_slot(input int s, input logic [TAG_W-1:0] dst, input logic [DATA_W-1:0] v1,
                            input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] q1,
                            input logic [TAG_W-1:0] q2, input bit r1, input bit r2);
        dispatch_valid[s]                 = 1'b1;
        dispatch_op[s*OP_W +: OP_W]       = {$urandom, $urandom};
        dispatch_dst[s*TAG_W +: TAG_W]    = dst;
        dispatch_v1[s*DATA_W +: DATA_W]   = v1;
        dispatch_v2[s*DATA_W +: DATA_W]   = v2;
        dispatch_q1[s*TAG_W +: TAG_W]     = q1;
        dispatch_q2[s*TAG_W +: TAG_W]     = q2;
        dispatch_r1[s]                    = r1;
        dispatch_r2[s]                    = r2;
    endtask

    task automatic set_cdb(input int c, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
        cdb_valid[c]                = 1'b1;
        cdb_tag[c*TAG_W +: TAG_W]   = tag;
        cdb_val[c*DATA_W +: DATA_W] = val;
    endtask

    // Called just after a falling edge with inputs applied: compares outputs
    // against the model, then advances the model across the next rising edge.
    task automatic cycle();
        bit               exp_en [ISSUE_W];
        bit               used [RS_DEPTH];
        bit               ready_pre;
        logic [DATA_W-1:0] val;
        ent_t             e;
        #1;
        ready_pre = (RS_DEPTH - mq.size()) >= DISPATCH_W;
        check("free_count", free_count, RS_DEPTH - mq.size());
        check("issue_ready", issue_ready, ready_pre);
        foreach (used[p]) used[p] = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            exp_en[k] = 1'b0;
            if (alu_ready[k] && !flush) begin
                for (int p = 0; p < mq.size(); p++) begin
                    if (!used[p] && mq[p].r1 && mq[p].r2) begin
                        used[p]   = 1'b1;
                        exp_en[k] = 1'b1;
                        check($sformatf("uop[%0d]", k), alu_uop[k*OP_W +: OP_W], mq[p].op);
                        check($sformatf("v1[%0d]", k), alu_v1[k*DATA_W +: DATA_W], mq[p].v1);
                        check($sformatf("v2[%0d]", k), alu_v2[k*DATA_W +: DATA_W], mq[p].v2);
                        check($sformatf("dst[%0d]", k), alu_dst[k*TAG_W +: TAG_W], mq[p].dst);
                        break;
                    end
                end
            end
            check($sformatf("alu_en[%0d]", k), alu_en[k], exp_en[k]);
            exp_issue += 32'(exp_en[k]);
        end
        if ((|dispatch_valid) && !ready_pre)
            exp_stall++;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            foreach (mq[p]) begin
                if (!mq[p].r1 && cdb_find(mq[p].q1, val)) begin mq[p].r1 = 1'b1; mq[p].v1 = val; end
                if (!mq[p].r2 && cdb_find(mq[p].q2, val)) begin mq[p].r2 = 1'b1; mq[p].v2 = val; end
            end
            for (int p = mq.size() - 1; p >= 0; p--)
                if (used[p]) mq.delete(p);
            if (ready_pre) begin
                for (int s = 0; s < DISPATCH_W; s++) begin
                    if (dispatch_valid[s]) begin
                        e.op  = dispatch_op[s*OP_W +: OP_W];
                        e.dst = dispatch_dst[s*TAG_W +: TAG_W];
                        e.v1  = dispatch_v1[s*DATA_W +: DATA_W];
                        e.v2  = dispatch_v2[s*DATA_W +: DATA_W];
                        e.q1  = dispatch_q1[s*TAG_W +: TAG_W];
                        e.q2  = dispatch_q2[s*TAG_W +: TAG_W];
                        e.r1  = dispatch_r1[s];
                        e.r2  = dispatch_r2[s];
                        if (!e.r1 && cdb_find(e.q1, val)) begin e.r1 = 1'b1; e.v1 = val; end
                        if (!e.r2 && cdb_find(e.q2, val)) begin e.r2 = 1'b1; e.v2 = val; end
                        mq.push_back(e);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        alu_ready = 2'b11;
        dispatch_op = '0; dispatch_dst = '0; dispatch_v1 = '0; dispatch_v2 = '0;
        dispatch_q1 = '0; dispatch_q2 = '0; cdb_tag = '0; cdb_val = '0;
        clear_inputs();
        #12;
        check("rst_free", free_count, 16);
        check("rst_ready", issue_ready, 1);
        check("rst_en", alu_en, 0);
        check("rst_uop", alu_uop, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four ready uops, two ports: pairs issue oldest-first
        for (int i = 1; i <= 4; i++)
            set_slot(i - 1, TAG_W'(i), DATA_W'(10 * i), DATA_W'(i), '0, '0, 1'b1, 1'b1);
        cycle(); clear_inputs();
        check("d1_free12", free_count, 12);
        check("d1_en_a", alu_en, 2'b11);
        check("d1_dst0_a", alu_dst[0 +: TAG_W], 1);
        check("d1_dst1_a", alu_dst[TAG_W +: TAG_W], 2);
        check("d1_v1_a", alu_v1[0 +: DATA_W], 10);
        cycle();
        check("d1_free14", free_count, 14);
        check("d1_dst0_b", alu_dst[0 +: TAG_W], 3);
        check("d1_dst1_b", alu_dst[TAG_W +: TAG_W], 4);
        cycle();
        check("d1_free16", free_count, 16);
        check("d1_idle", alu_en, 0);

        // Blocked source woken by CDB channel 2
        set_slot(0, 6'd20, 32'h0, 32'h5, 6'd7, 6'd0, 1'b0, 1'b1);
        cycle(); clear_inputs();
        for (int i = 0; i < 3; i++) begin
            check("d2_blocked", alu_en, 0);
            cycle();
        end
        set_cdb(2, 6'd7, 32'hDEAD);
        cycle(); clear_inputs();
        check("d2_en", alu_en, 2'b01);
        check("d2_v1", alu_v1[0 +: DATA_W], 32'hDEAD);
        cycle();

        // Same-cycle dispatch and broadcast: no lost wakeup
        set_slot(0, 6'd21, 32'h11, 32'h0, 6'd0, 6'd9, 1'b1, 1'b0);
        set_cdb(0, 6'd9, 32'h1234);
        cycle(); clear_inputs();
        check("d3_en", alu_en, 2'b01);
        check("d3_v2", alu_v2[0 +: DATA_W], 32'h1234);
        cycle();

        // Fill all entries with blocked uops, then wake the two oldest
        for (int g = 0; g < 4; g++) begin
            for (int s = 0; s < DISPATCH_W; s++)
                set_slot(s, TAG_W'(g * 4 + s), DATA_W'(g * 4 + s), '0, TAG_W'(32 + g * 4 + s), '0, 1'b0, 1'b1);
            cycle(); clear_inputs();
        end
        check("d4_full_free", free_count, 0);
        check("d4_full_ready", issue_ready, 0);
        set_cdb(0, 6'd32, 32'hA0);
        set_cdb(1, 6'd33, 32'hA1);
        cycle(); clear_inputs();
        check("d4_en", alu_en, 2'b11);
        check("d4_dst0", alu_dst[0 +: TAG_W], 0);
        check("d4_dst1", alu_dst[TAG_W +: TAG_W], 1);
        check("d4_v1_1", alu_v1[DATA_W +: DATA_W], 32'hA1);
        cycle();
        check("d4_free2", free_count, 2);
        check("d4_ready_low", issue_ready, 0);
        flush = 1'b1;
        cycle(); clear_inputs();
        check("d4_flush_free", free_count, 16);

        // Only port 1 ready: it carries the oldest, port 0 idle
        alu_ready = 2'b10;
        for (int s = 0; s < 3; s++)
            set_slot(s, TAG_W'(11 + s), DATA_W'(s), '0, '0, '0, 1'b1, 1'b1);
        cycle(); clear_inputs();
        check("d5_en", alu_en, 2'b10);
        check("d5_dst1", alu_dst[TAG_W +: TAG_W], 11);
        repeat (3) cycle();

        // Flush with six residents and a concurrent dispatch
        alu_ready = 2'b00;
        for (int s = 0; s < 4; s++)
            set_slot(s, TAG_W'(s), '0, '0, TAG_W'(48 + s), '0, 1'b0, 1'b1);
        cycle(); clear_inputs();
        for (int s = 0; s < 2; s++)
            set_slot(s, TAG_W'(s), '0, '0, TAG_W'(52 + s), '0, 1'b0, 1'b1);
        cycle(); clear_inputs();
        check("d6_free10", free_count, 10);
        alu_ready = 2'b11;
        flush = 1'b1;
        for (int s = 0; s < 4; s++)
            set_slot(s, TAG_W'(s), '0, '0, '0, '0, 1'b1, 1'b1);
        #1;
        check("d6_flush_en", alu_en, 0);
        cycle(); clear_inputs();
        check("d6_free16", free_count, 16);
        for (int c = 0; c < 4; c++) set_cdb(c, TAG_W'(48 + c), '0);
        cycle(); clear_inputs();
        set_cdb(0, 6'd52, '0); set_cdb(1, 6'd53, '0);
        cycle(); clear_inputs();
        check("d6_no_issue", alu_en, 0);
        cycle();

        // Asynchronous reset mid-operation overrides a pending dispatch
        for (int s = 0; s < 4; s++)
            set_slot(s, TAG_W'(s), '0, '0, TAG_W'(54 + s), '0, 1'b0, 1'b1);
        cycle(); clear_inputs();
        for (int s = 0; s < 2; s++)
            set_slot(s, TAG_W'(s), '0, '0, '0, '0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst2_free", free_count, 16);
        check("rst2_en", alu_en, 0);
        mq.delete();
        exp_stall = 0;
        exp_issue = 0;
        @(posedge clk); #1;
        check("rst2_hold", free_count, 16);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            flush     = ($urandom_range(0, 49) == 0);
            alu_ready = ISSUE_W'($urandom);
            if ((RS_DEPTH - mq.size()) >= DISPATCH_W) begin
                for (int s = 0; s < DISPATCH_W; s++) begin
                    if ($urandom_range(0, 1) == 1)
                        set_slot(s, TAG_W'($urandom), $urandom, $urandom,
                                 TAG_W'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 15)),
                                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
                end
            end
            for (int c = 0; c < CDB_W; c++) begin
                if ($urandom_range(0, 1) == 1)
                    set_cdb(c, TAG_W'($urandom_range(0, 15)), $urandom);
            end
            cycle();
        end
        clear_inputs();

`ifdef ISSUE_QUEUE_PERF_CNT_EN
        check("stall_cnt", stall_cnt, exp_stall);
        check("issue_cnt", issue_cnt, exp_issue);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
